// File: rtl/c1_dtack_sched.sv
// c1_dtack_sched: 68K bus-cycle sequencer for C1.
// Latches the address zone at cycle start and inserts per-zone wait states.
// It then acknowledges with nDTACK, or waits for an external PDTACK with a
// timeout that ends in nBERR.
//
// state | meaning
// ------+---------------------------------------------
// IDLE  | no cycle in progress
// WAIT  | counting wait states for the latched zone
// EXT   | waiting for PDTACK, timeout counter running
// ACK   | nDTACK asserted until nAS goes high
// BERR  | nBERR asserted until nAS goes high
module c1_dtack_sched #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned DEF_WAIT       = 3
) (
  input  logic       CLK_68KCLK,
  input  logic       RESET,
  input  logic       nAS,
  input  logic       nROM_ZONE,
  input  logic       nPORT_ZONE,
  input  logic       nCARD_ZONE,
  input  logic       CFG_WE,
  input  logic [7:0] CFG_DATA,
  input  logic       PDTACK,
  output logic       nDTACK,
  output logic       nBERR,
  output logic       BUSY,
  output logic [1:0] ZONE,
  output logic [7:0] CFG_Q
);

  localparam logic [7:0] TIMEOUT_VAL  = 8'(TIMEOUT_CYCLES);
  localparam logic [1:0] DEF_WAIT_VAL = 2'(DEF_WAIT);

  localparam logic [1:0] ZONE_OTHER = 2'd0;
  localparam logic [1:0] ZONE_ROM   = 2'd1;
  localparam logic [1:0] ZONE_PORT  = 2'd2;
  localparam logic [1:0] ZONE_CARD  = 2'd3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    EXT  = 3'd2,
    ACK  = 3'd3,
    BERR = 3'd4
  } stateT;

  stateT       state, stateNext;
  logic [7:0]  cfgReg;
  logic [7:0]  cfgMasked;
  logic [1:0]  zoneReg, zoneNext;
  logic [1:0]  waitCnt, waitCntNext;
  logic        extReg, extNext;
  logic [7:0]  toCnt, toCntNext, toCntInc;
  logic [1:0]  startZone;
  logic [1:0]  startWait;
  logic        startExt;
  // Cleared by reset; a cycle may only start once nAS has been seen high, so a
  // cycle cut off by reset is not restarted while the CPU still holds nAS low.
  logic        asArmed;

  assign cfgMasked = CFG_DATA & 8'h3F;
  assign toCntInc  = toCnt + 8'd1;

  // Configuration register; reserved bits always read back as zero.
  always_ff @(posedge CLK_68KCLK) begin
    if (RESET) begin
      cfgReg <= 8'h00;
    end else if (CFG_WE) begin
      cfgReg <= cfgMasked;
    end
  end

  // Zone decode and per-zone wait/ext selection, used only at cycle start.
  always_comb begin
    startZone = ZONE_OTHER;
    if (!nROM_ZONE) begin
      startZone = ZONE_ROM;
    end else if (!nPORT_ZONE) begin
      startZone = ZONE_PORT;
    end else if (!nCARD_ZONE) begin
      startZone = ZONE_CARD;
    end
    case (startZone)
      ZONE_ROM:  startWait = {1'b0, cfgReg[0]};
      ZONE_PORT: startWait = cfgReg[2:1];
      ZONE_CARD: startWait = cfgReg[4:3];
      default:   startWait = DEF_WAIT_VAL;
    endcase
    startExt = (startZone == ZONE_PORT) && cfgReg[5];
  end

  // Next-state and counter logic; nAS high aborts from any state.
  always_comb begin
    stateNext   = state;
    zoneNext    = zoneReg;
    waitCntNext = waitCnt;
    extNext     = extReg;
    toCntNext   = toCnt;
    if (nAS) begin
      stateNext   = IDLE;
      waitCntNext = 2'd0;
      toCntNext   = 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (asArmed) begin
            zoneNext  = startZone;
            extNext   = startExt;
            toCntNext = 8'd0;
            if (startWait != 2'd0) begin
              stateNext   = WAIT;
              waitCntNext = startWait;
            end else if (startExt) begin
              stateNext = EXT;
            end else begin
              stateNext = ACK;
            end
          end
        end
        WAIT: begin
          waitCntNext = waitCnt - 2'd1;
          if (waitCnt == 2'd1) begin
            stateNext = extReg ? EXT : ACK;
          end
        end
        EXT: begin
          // PDTACK wins over a timeout landing on the same edge.
          if (PDTACK) begin
            stateNext = ACK;
          end else begin
            toCntNext = toCntInc;
            if (toCntInc == TIMEOUT_VAL) begin
              stateNext = BERR;
            end
          end
        end
        ACK:     stateNext = ACK;
        BERR:    stateNext = BERR;
        default: stateNext = IDLE;
      endcase
    end
  end

  // State, counters and registered bus strobes.
  always_ff @(posedge CLK_68KCLK) begin
    if (RESET) begin
      state   <= IDLE;
      zoneReg <= ZONE_OTHER;
      waitCnt <= 2'd0;
      extReg  <= 1'b0;
      toCnt   <= 8'd0;
      nDTACK  <= 1'b1;
      nBERR   <= 1'b1;
      asArmed <= 1'b0;
    end else begin
      state   <= stateNext;
      zoneReg <= zoneNext;
      waitCnt <= waitCntNext;
      extReg  <= extNext;
      toCnt   <= toCntNext;
      nDTACK  <= (stateNext != ACK);
      nBERR   <= (stateNext != BERR);
      if (nAS) begin
        asArmed <= 1'b1;
      end
    end
  end

  assign BUSY  = (state != IDLE);
  assign ZONE  = zoneReg;
  assign CFG_Q = cfgReg;

endmodule

// File: doc/c1_dtack_sched.md
# c1_dtack_sched

Bus-cycle sequencer for the 68K side of C1. It latches the active address zone at the start of each cycle and inserts a programmable number of wait states per zone. It then either asserts nDTACK or hands off to an external PDTACK handshake, with a timeout that raises nBERR. It replaces free-running wait counting with an explicit per-cycle state machine and a CPU-writable wait configuration register.

## Interface
- TIMEOUT_CYCLES, 64: number of clock edges allowed in the external-ack state before bus error; range 2..255.
- DEF_WAIT, 3: wait states for accesses outside ROM/PORT/CARD zones; range 0..3.
- CLK_68KCLK  in  1  68K bus clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- nAS  in  1  68K address strobe, active low, already synchronous to CLK_68KCLK.
- nROM_ZONE  in  1  ROM zone decode, active low.
- nPORT_ZONE  in  1  cartridge port zone decode, active low.
- nCARD_ZONE  in  1  memory card zone decode, active low.
- CFG_WE  in  1  config register write strobe, one cycle.
- CFG_DATA  in  8  config value:
  - [0] ROM wait (0..1)
  - [2:1] PORT wait (0..3)
  - [4:3] CARD wait (0..3)
  - [5] PORT_EXT: wait for PDTACK after PORT wait states
  - [7:6] reserved, read as 0
- PDTACK  in  1  external acknowledge from port device, active high.
- nDTACK  out  1  data acknowledge to 68K, active low, registered.
- nBERR  out  1  bus error to 68K, active low, registered.
- BUSY  out  1  high whenever state != IDLE.
- ZONE  out  2  zone latched for the current cycle: 0=other, 1=ROM, 2=PORT, 3=CARD.
- CFG_Q  out  8  current config register contents.

## Operation
- States:
  - IDLE: no cycle in progress.
  - WAIT: counting wait states.
  - EXT: waiting for PDTACK.
  - ACK: nDTACK asserted.
  - BERR: nBERR asserted.
- Config register:
  - Reset value 8'h00.
  - On CFG_WE, loads CFG_DATA with bits [7:6] forced to 0.
  - A write lands at the edge where CFG_WE is sampled. It affects only cycles whose E0 is later than that edge.
- IDLE → cycle start (edge E0): nAS sampled low.
  - Latch zone with priority ROM > PORT > CARD > other.
  - Latch N = zone wait (ROM uses CFG[0]; other uses DEF_WAIT) and EXT = (zone==PORT && CFG[5]).
  - N>0 → WAIT with 2-bit counter = N.
  - N=0 and !EXT → ACK.
  - N=0 and EXT → EXT.
- WAIT: counter decrements each edge. On the edge it decrements 1→0, go to ACK, or to EXT if EXT is set.
- EXT: a 8-bit timeout counter starts at 0 on entry and increments each edge with PDTACK low.
  - PDTACK sampled high → ACK.
  - Counter reaching TIMEOUT_CYCLES → BERR.
  - PDTACK high on the timeout edge: ACK wins.
- ACK: nDTACK=0. BERR: nBERR=0. Both hold until nAS is sampled high.
- nAS sampled high in any state → IDLE. nDTACK and nBERR return to 1 at that edge. Counters are cleared.
  - This abort applies in WAIT and EXT as well; no acknowledge is issued for an aborted cycle.
- Zone inputs are sampled only at E0. Zone changes during a cycle are ignored.
- Back-to-back cycles: nAS high for one edge returns to IDLE; nAS low at the next edge starts a new E0.
- RESET takes priority over all other inputs:
  - State → IDLE, nDTACK=1, nBERR=1, BUSY=0, ZONE=0, CFG=8'h00, counters=0.
  - A cycle in progress when reset hits is dropped without ack.

## Timing
- nDTACK falls at edge E0+N when EXT=0. N=0 gives nDTACK low after E0, i.e. one cycle after nAS is seen.
- With EXT=1, entry to EXT is at E0+N. nDTACK falls at the edge where PDTACK is sampled high, at the earliest E0+N+1.
- nBERR falls at edge E0+N+TIMEOUT_CYCLES if PDTACK never rises.
- nDTACK/nBERR rise at the first edge with nAS sampled high. There is no extra latency.
- BUSY rises at E0 and falls at the edge returning to IDLE.
- nDTACK and nBERR are never low simultaneously.

## Test plan
- **Reset:** assert RESET mid-WAIT (ROM, CFG=8'h01) → next edge nDTACK=1, nBERR=1, BUSY=0, CFG_Q=8'h00; no ack follows even if nAS stays low.
- **ROM zone:**
  - CFG=8'h00, nROM_ZONE=0, nAS low at E0 → nDTACK low after E0, ZONE=1.
  - CFG=8'h01 → nDTACK low after E0+1.
  - nDTACK rises on the first edge with nAS high.
- **Port zone:** CFG=8'h06 (PORT wait 3, no ext), nPORT_ZONE=0 → nDTACK low at E0+3, ZONE=2.
- **Other zone:** all zone inputs high → nDTACK low at E0+DEF_WAIT (3).
- **External ack:**
  - CFG=8'h20, nPORT_ZONE=0, PDTACK high at E0+5 → nDTACK low at E0+5, nBERR stays 1.
  - Repeat with PDTACK held low → nBERR low at E0+64, nDTACK stays 1.
  - PDTACK rising on the timeout edge → nDTACK low, nBERR stays 1.
- **Mid-cycle changes:**
  - CFG_WE with 8'h18 during a CARD cycle started with CARD wait 0 → current cycle acks at E0. The next CARD cycle acks at E0+3.
  - Zone inputs toggled mid-cycle → ZONE unchanged.
  - nAS raised during WAIT → IDLE next edge, nDTACK never asserted.
